// File: rtl/updi_frame_builder.sv
// Reads a length-prefixed packet from CPU_MEM and streams it as a UPDI frame:
// SYNCH byte first, then the packet's frame bytes, over a valid/ready byte stream.
module updi_frame_builder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned RAM_DEPTH  = 128,
    parameter int unsigned MAX_LEN    = 16,
    parameter logic [DATA_WIDTH-1:0] SYNCH = 'h55
) (
    input  logic                  clk0,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  mem_csb,
    output logic                  mem_web,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    localparam int unsigned CntW    = $clog2(MAX_LEN + 1);
    localparam logic [7:0]  MaxLenB = 8'(MAX_LEN);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StLenWait  = 3'd1;
    localparam logic [2:0] StSync     = 3'd2;
    localparam logic [2:0] StDataWait = 3'd3;
    localparam logic [2:0] StData     = 3'd4;

    logic [2:0]            state_q, state_d;
    logic                  wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  mem_csb_q, mem_csb_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [7:0]            len;

    // Address increment wraps at RAM_DEPTH, which need not be a power of two.
    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
        if (a == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
            return '0;
        end
        return a + 1'b1;
    endfunction

    assign len = mem_dout[7:0];

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        mem_csb_d  = 1'b1;
        mem_addr_d = mem_addr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mem_csb_d  = 1'b0;
                    mem_addr_d = base_addr;
                    ptr_d      = addr_inc(base_addr);
                    wait_d     = 1'b0;
                    state_d    = StLenWait;
                end
            end
            StLenWait: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else if (len == 8'd0 || len > MaxLenB) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d      = CntW'(len);
                    tx_data_d  = SYNCH;
                    tx_valid_d = 1'b1;
                    state_d    = StSync;
                end
            end
            StSync: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    mem_csb_d  = 1'b0;
                    mem_addr_d = ptr_q;
                    wait_d     = 1'b0;
                    state_d    = StDataWait;
                end
            end
            StDataWait: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else begin
                    tx_data_d  = mem_dout;
                    tx_valid_d = 1'b1;
                    state_d    = StData;
                end
            end
            StData: begin
                if (tx_ready) begin
                    ptr_d      = addr_inc(ptr_q);
                    cnt_d      = cnt_q - 1'b1;
                    tx_valid_d = 1'b0;
                    if (cnt_q == CntW'(1)) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        mem_csb_d  = 1'b0;
                        mem_addr_d = addr_inc(ptr_q);
                        wait_d     = 1'b0;
                        state_d    = StDataWait;
                    end
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk0) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_q     <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_csb_q  <= 1'b1;
            mem_addr_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            mem_csb_q  <= mem_csb_d;
            mem_addr_q <= mem_addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign mem_csb  = mem_csb_q;
    assign mem_web  = 1'b1;
    assign mem_addr = mem_addr_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_updi_frame_builder.sv
// Bench for updi_frame_builder: CPU_MEM model, vector table, hand sequences and random frames
// checked against a packet-level reference model.
module tb_updi_frame_builder;

    logic       clk0 = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] base_addr = '0;
    logic       busy, done, err, mem_csb, mem_web;
    logic [6:0] mem_addr;
    logic [7:0] mem_dout = '0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [128];
    logic       csb_r = 1'b1;
    logic [6:0] addr_r = '0;
    logic [6:0] rd_log [$];

    updi_frame_builder dut (
        .clk0      (clk0),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_csb   (mem_csb),
        .mem_web   (mem_web),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    always #5 clk0 = ~clk0;

    // CPU_MEM: inputs registered on the rising edge, dout updated on the falling edge
    always @(posedge clk0) begin
        csb_r  <= mem_csb;
        addr_r <= mem_addr;
        if (!mem_csb) rd_log.push_back(mem_addr);
    end
    always @(negedge clk0) if (!csb_r) mem_dout <= mem[addr_r];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_csb"}, int'(mem_csb), 1);
        chk({tag, "_web"}, int'(mem_web), 1);
        chk({tag, "_addr"}, int'(mem_addr), 0);
        chk({tag, "_txdata"}, int'(tx_data), 0);
        chk({tag, "_txvalid"}, int'(tx_valid), 0);
    endtask

    // mode: 0 ready always, 1 five stall cycles per byte, 2 random ready
    task automatic run_frame(input int base, input int mode, input bit ign,
                             input bit exp_err, input int exp_end);
        logic [7:0] expq [$];
        logic [7:0] got [$];
        logic [6:0] exp_rd [$];
        int L, end_j, done_cnt, err_cnt, stable_bad, csb_bad, web_bad, busy_bad, vcnt, rd_ok;
        bit prev_stall, csb_prev, r;
        logic [7:0] prev_data;

        L = int'(mem[base]);
        exp_rd.push_back(7'(base));
        if (!exp_err) begin
            expq.push_back(8'h55);
            for (int i = 1; i <= L; i++) begin
                expq.push_back(mem[(base + i) % 128]);
                exp_rd.push_back(7'((base + i) % 128));
            end
        end

        end_j = -1; done_cnt = 0; err_cnt = 0; stable_bad = 0; csb_bad = 0; web_bad = 0;
        busy_bad = 0; vcnt = 0; prev_stall = 0; csb_prev = 1; prev_data = '0;
        @(negedge clk0);
        rd_log.delete();
        start = 1'b1;
        base_addr = 7'(base);
        for (int j = 0; j < 600 && !(end_j >= 0 && j > end_j + 3); j++) begin
            @(negedge clk0);
            if (j == 0) begin
                start = 1'b0;
                base_addr = 7'($urandom);
            end
            if (ign && j == 4) begin
                start = 1'b1;
                base_addr = 7'((base + 37) % 128);
            end
            if (ign && j == 5) start = 1'b0;
            if (prev_stall && (!tx_valid || tx_data !== prev_data)) stable_bad++;
            if (!mem_csb && !csb_prev) csb_bad++;
            csb_prev = mem_csb;
            if (mem_web !== 1'b1) web_bad++;
            if (done) done_cnt++;
            if (err) err_cnt++;
            if ((done || err) && end_j < 0) end_j = j;
            if (end_j < 0) begin
                if (!busy) busy_bad++;
            end else if (busy) busy_bad++;
            case (mode)
                0: r = 1'b1;
                1: r = (vcnt >= 5);
                default: r = 1'($urandom_range(0, 1));
            endcase
            if (tx_valid) begin
                if (r) begin
                    got.push_back(tx_data);
                    vcnt = 0;
                end else vcnt++;
            end
            prev_stall = tx_valid && !r;
            prev_data = tx_data;
            tx_ready = r;
        end

        chk("frame_end_seen", int'(end_j >= 0), 1);
        if (exp_end >= 0) chk("end_cycle", end_j, exp_end);
        chk("err_pulses", err_cnt, exp_err ? 1 : 0);
        chk("done_pulses", done_cnt, exp_err ? 0 : 1);
        chk("stream_len", got.size(), expq.size());
        for (int i = 0; i < got.size() && i < expq.size(); i++)
            chk($sformatf("stream_byte%0d", i), int'(got[i]), int'(expq[i]));
        chk("stall_stable", stable_bad, 0);
        chk("csb_one_cycle", csb_bad, 0);
        chk("web_high", web_bad, 0);
        chk("busy_profile", busy_bad, 0);
        rd_ok = (rd_log.size() == exp_rd.size()) ? 1 : 0;
        for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
            if (rd_log[i] !== exp_rd[i]) rd_ok = 0;
        chk("read_addrs", rd_ok, 1);
    endtask

    typedef struct {
        int base;
        int len;
        int mode;
        bit ign;
        bit exp_err;
        int exp_end;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int hs, hit, spurious, b, l;

        vecs[0] = '{10, 3, 0, 0, 0, 12};
        vecs[1] = '{20, 0, 0, 0, 1, 2};
        vecs[2] = '{20, 17, 0, 0, 1, 2};
        vecs[3] = '{126, 2, 0, 0, 0, 9};
        vecs[4] = '{30, 3, 1, 0, 0, -1};
        vecs[5] = '{40, 4, 0, 1, 0, 15};
        vecs[6] = '{50, 16, 0, 0, 0, 51};
        vecs[7] = '{60, 255, 0, 0, 1, 2};
        vecs[8] = '{70, 1, 0, 0, 0, 6};

        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        mem[11] = 8'h12;
        mem[12] = 8'h34;
        mem[13] = 8'h56;

        repeat (3) @(negedge clk0);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk0);

        for (int v = 0; v < 9; v++) begin
            mem[vecs[v].base] = 8'(vecs[v].len);
            run_frame(vecs[v].base, vecs[v].mode, vecs[v].ign, vecs[v].exp_err, vecs[v].exp_end);
        end

        // Reset while the second data byte is on the stream
        mem[10] = 8'd3;
        hs = 0;
        hit = 0;
        @(negedge clk0);
        start = 1'b1;
        base_addr = 7'd10;
        tx_ready = 1'b1;
        for (int j = 0; j < 100 && hit == 0; j++) begin
            @(negedge clk0);
            start = 1'b0;
            if (tx_valid) begin
                if (hs == 2) hit = 1;
                else hs++;
            end
        end
        chk("rst_point_reached", hit, 1);
        rst = 1'b1;
        @(negedge clk0);
        check_reset_vals("midrst");
        rst = 1'b0;
        spurious = 0;
        repeat (10) begin
            @(negedge clk0);
            if (done || err || tx_valid || busy) spurious++;
        end
        chk("post_rst_quiet", spurious, 0);
        run_frame(10, 0, 0, 0, 12);

        for (int n = 0; n < 20; n++) begin
            b = int'($urandom_range(0, 127));
            l = int'($urandom_range(0, 18));
            mem[b] = 8'(l);
            for (int i = 1; i <= l; i++) mem[(b + i) % 128] = 8'($urandom);
            run_frame(b, (n % 3 == 0) ? 1 : 2, 0, (l == 0 || l > 16), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/updi_frame_builder.md
# updi_frame_builder

Downstream stage of the CPU packet memory. On a start request it reads one CPU-loaded packet through a read-only port of CPU_MEM and streams it as a UPDI command frame: SYNCH byte 0x55, then the packet's frame bytes. The output is a byte-wide valid/ready stream feeding the UPDI UART transmitter.

## Interface
- DATA_WIDTH, 8, byte width of the memory and the TX stream
- ADDR_WIDTH, 7, CPU_MEM address width
- RAM_DEPTH, 128, CPU_MEM depth; address arithmetic wraps modulo this value
- MAX_LEN, 16, largest legal packet length in bytes
- SYNCH, 8'h55, first byte of every frame

Ports:
- clk0  in  1  clock; all logic runs on the rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request to send the packet at base_addr; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  packet start address in CPU_MEM
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle pulse after the last frame byte is accepted
- err  out  1  one-cycle pulse when the packet length is illegal
- mem_csb  out  1  CPU_MEM chip select, active low
- mem_web  out  1  CPU_MEM write enable; constant 1 (read only)
- mem_addr  out  ADDR_WIDTH  CPU_MEM address
- mem_dout  in  DATA_WIDTH  CPU_MEM read data
- tx_data  out  DATA_WIDTH  frame byte to the UART TX
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  UART TX accepts the byte when tx_valid is also high

## Operation
- Packet layout in CPU_MEM: mem[base] = length L, followed by mem[base+1 .. base+L] = frame bytes. All addresses are computed modulo RAM_DEPTH.
- Memory read protocol:
  - mem_csb is driven low, registered, for exactly one cycle per read, with mem_addr valid in that same cycle.
  - CPU_MEM registers its inputs on the next rising edge and updates dout on the following falling edge.
  - mem_dout is sampled on the 2nd rising edge after the edge that drove mem_csb low.
- All outputs are registered. mem_addr holds its last value when idle.
- States:
  - IDLE: start=1 → mem_csb=0, mem_addr=base_addr, ptr=base_addr+1, go to LEN_WAIT. busy rises on the same edge.
  - LEN_WAIT: 2-cycle wait, then capture L.
    - If L==0 or L>MAX_LEN: err pulse, go to IDLE, and nothing is sent.
    - Otherwise: cnt=L, tx_data=SYNCH, tx_valid=1, go to SYNC.
  - SYNC: on handshake, drop tx_valid, issue a read at ptr, go to DATA_WAIT.
  - DATA_WAIT: 2-cycle wait, then tx_data=mem_dout, tx_valid=1, go to DATA.
  - DATA: on handshake, ptr=ptr+1 (wrapping), cnt=cnt−1.
    - If the old cnt==1: tx_valid=0, done pulse, go to IDLE.
    - Otherwise: issue a read at the new ptr on the same edge, go to DATA_WAIT.
- Handshake rules: tx_data and tx_valid stay stable while tx_valid=1 and tx_ready=0. tx_valid never drops without a handshake, except on reset.
- start while busy is ignored; it is neither queued nor allowed to alter base_addr.
- L is used as an 8-bit unsigned value. cnt is $clog2(MAX_LEN+1) bits wide.

## Timing
- Reset values: busy=0, done=0, err=0, mem_csb=1, mem_web=1, mem_addr=0, tx_data=0, tx_valid=0. State is IDLE.
- Reset mid-operation aborts the frame immediately. No done or err pulse is generated, and tx_valid drops on the reset edge.
- start sampled at edge E0:
  - E0: mem_csb low.
  - E2: L captured.
  - Cycle after E2: tx_valid=1 with 0x55.
- Byte-to-byte: handshake at edge Ea → next byte valid after Ea+2. With tx_ready held high, a byte is accepted every 3 cycles.
- Frame from start to done for length L with tx_ready=1: done is high in the cycle after edge E0 + 3 + 3·L.
- done and err are mutually exclusive and are never high for more than one cycle.
- A new start is accepted in the first cycle that busy is low after done or err.

## Test plan
- mem[10]=3, mem[11..13]=0x12,0x34,0x56, start with base 10, tx_ready=1 → stream 0x55,0x12,0x34,0x56; done pulses in the cycle after E0+12; mem_web is 1 throughout.
- mem[20]=0 and, separately, mem[20]=17 → err one-cycle pulse, no tx_valid, busy low again 3 cycles after start.
- Wrap-around: base 126 with L=2, data at addresses 127 and 0 → reads issued at 126, 127, 0; stream is 0x55, mem[127], mem[0].
- Backpressure: tx_ready low for 5 cycles on each byte → tx_data/tx_valid held stable, no byte lost or duplicated, bytes arrive in order.
- Pulse start during a frame with a different base_addr → ignored; the current frame completes unchanged and no second frame is sent.
- Assert rst while the 2nd data byte is valid → all outputs take reset values on the next edge, no done pulse; a following start sends a complete frame.
